backing_line_ram: RTL and testbench



---
 rtl/backing_line_ram.sv | 115 +++++++++++
 tb/tb_backing_line_ram.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/backing_line_ram.sv
// Line-granular backing store: one 20-bit line per transaction, LATENCY access cycles then a DONE cycle.
// Latency LATENCY+1 from accept to ready; commands arriving during ACCESS are dropped (no queuing), next accept at DONE.
module backing_line_ram #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cmd,
    input  logic [8:0]  addr,
    input  logic [19:0] wdata,
    output logic [19:0] rdata,
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WR = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  addr_q, addr_d;
    logic [19:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [19:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        mem_we;

    logic [19:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (cmd == CMD_RD || cmd == CMD_WR) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    is_wr_d = (cmd == CMD_WR);
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Only the latched request is used here; live cmd/addr/wdata are ignored.
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 9'd0;
            wdata_q <= 20'd0;
            is_wr_q <= 1'b0;
            rdata_q <= 20'h00000;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Array is never reset; a reset during ACCESS suppresses the pending write.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_backing_line_ram.sv
// Bench for backing_line_ram at LATENCY=3: a vector table plus hand sequences for reset, busy-ignore,
// back-to-back and illegal commands; a scoreboard matches every ready pulse against expected rdata and cycle.
module tb_backing_line_ram;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [19:0] wdata;
    logic [19:0] rdata;
    logic        ready;
    logic        busy;

    backing_line_ram #(.LATENCY(LAT), .DEPTH(512)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [19:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [19:0] wdata;
        logic [19:0] exp_rdata;
    } vec_t;
    vec_t vt[10];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_rdata", 32'(rdata), 32'(e.rdata));
                check("sb_ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [19:0] d);
        cmd   = c;
        addr  = a;
        wdata = d;
    endtask

    task automatic expect_done(input logic [19:0] r);
        exp_t e;
        e.rdata = r;
        e.cyc   = cyc + 1 + LAT;
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: pending %0d busy %0b", sbq.size(), busy);
        end
    endtask

    task automatic do_txn(input logic [1:0] c, input logic [8:0] a, input logic [19:0] d,
                          input logic [19:0] exp_r);
        drive(c, a, d);
        expect_done(exp_r);
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
        drive(2'b00, 9'd0, 20'd0);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{2'b10, 9'h000, 20'h0001F, 20'h00000};
        vt[1] = '{2'b01, 9'h000, 20'h00000, 20'h0001F};
        vt[2] = '{2'b10, 9'h1FF, 20'h0F0F0, 20'h0001F};
        vt[3] = '{2'b01, 9'h1FF, 20'h00000, 20'h0F0F0};
        vt[4] = '{2'b10, 9'h021, 20'h0ABCD, 20'h0F0F0};
        vt[5] = '{2'b10, 9'h010, 20'h00777, 20'h0F0F0};
        vt[6] = '{2'b01, 9'h021, 20'h00000, 20'h0ABCD};
        vt[7] = '{2'b10, 9'h100, 20'hFFFFF, 20'h0ABCD};
        vt[8] = '{2'b01, 9'h010, 20'h00000, 20'h00777};
        vt[9] = '{2'b01, 9'h100, 20'h00000, 20'hFFFFF};

        // Reset wins over a command presented at the same edge.
        reset = 1'b0;
        drive(2'b01, 9'h000, 20'd0);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);

        // Vector 0 is accepted at the first edge with reset released.
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_txn(vt[i].cmd, vt[i].addr, vt[i].wdata, vt[i].exp_rdata);
        end

        // Busy ignore: a write held during ACCESS must be dropped.
        drive(2'b01, 9'h021, 20'd0);
        expect_done(20'h0ABCD);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("ign_busy", 32'(busy), 32'd1);
            check("ign_ready", 32'(ready), 32'd0);
            drive(2'b10, 9'h021, 20'h3FFFF);
        end
        @(negedge clk);
        drive(2'b00, 9'd0, 20'd0);
        wait_drain();
        do_txn(2'b01, 9'h021, 20'd0, 20'h0ABCD);

        // Back-to-back: read issued in the DONE cycle of a write to the same line.
        drive(2'b10, 9'h1FF, 20'h55AAA);
        expect_done(20'h0ABCD);
        @(negedge clk);
        drive(2'b00, 9'd0, 20'd0);
        repeat (LAT) @(negedge clk);
        check("b2b_done_ready", 32'(ready), 32'd1);
        drive(2'b01, 9'h1FF, 20'd0);
        expect_done(20'h55AAA);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        drive(2'b00, 9'd0, 20'd0);
        wait_drain();

        // Reset on the second ACCESS cycle aborts the write.
        drive(2'b10, 9'h010, 20'h12345);
        @(negedge clk);
        drive(2'b00, 9'd0, 20'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_rdata", 32'(rdata), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        do_txn(2'b01, 9'h010, 20'd0, 20'h00777);

        // Illegal command held in IDLE has no effect.
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, 9'h010, 20'h3FFFF);
            @(negedge clk);
            check("ill_busy", 32'(busy), 32'd0);
            check("ill_ready", 32'(ready), 32'd0);
            check("ill_rdata", 32'(rdata), 32'h00777);
        end
        drive(2'b00, 9'd0, 20'd0);
        @(negedge clk);
        do_txn(2'b01, 9'h010, 20'd0, 20'h00777);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
